spi_req_arbiter: RTL and testbench

//  Shares one spi_master among NREQ requesters, each owning one SPI slave select.

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_req_arbiter_rr_arbiter.sv | 37 +++
 rtl/spi_req_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_pkg
// Brief    : Shared FSM encoding and counter width for the SPI request arbiter.
// Revision : 1.0
// ============================================================================
package spi_arb_pkg;

    localparam int c_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first set request at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt
);

    always_comb begin
        int  w_idx;
        logic w_found;
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr < NREQ, so a single subtraction implements the wrap
            w_idx = int'(ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (en && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_req_arbiter
// Brief    : Shares one spi_master among NREQ requesters with CS sequencing.
// Revision : 1.0
// ============================================================================
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [DW-1:0]      rx_data,
    output logic [NREQ-1:0]    ss_n,
    output logic               m_start,
    output logic [DW-1:0]      m_tx_data,
    input  logic               m_busy,
    input  logic               m_done,
    input  logic [DW-1:0]      m_rx_data
);

    localparam int                 c_IDX_W        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX     = c_IDX_W'(NREQ - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST   = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST    = c_CNT_W'(CS_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_IDX_W-1:0]  r_ptr;
    logic [c_IDX_W-1:0]  r_gidx;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic                r_err;
    logic                r_abort;
    logic [DW-1:0]       r_rx;
    logic [DW-1:0]       r_tx;

    logic                w_arb_en;
    logic [NREQ-1:0]     w_arb_gnt;
    logic [c_IDX_W-1:0]  w_arb_idx;
    logic                w_load;
    logic                w_capture;
    logic                w_timeout;
    logic                w_finish;

    assign w_arb_en = (r_state == ST_IDLE) && !m_busy;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .req (req),
        .ptr (r_ptr),
        .en  (w_arb_en),
        .gnt (w_arb_gnt)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_arb_gnt[k]) begin
                w_arb_idx = c_IDX_W'(k);
            end
        end
    end

    // Next-state logic; one shared counter serves SETUP, WAIT timeout and HOLD
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_arb_gnt) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
            end
            ST_WAIT: begin
                // m_done takes priority over a simultaneous timeout
                if (m_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
            r_rx    <= '0;
            r_tx    <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_load) begin
                r_gnt   <= w_arb_gnt;
                r_gidx  <= w_arb_idx;
                r_tx    <= req_data[int'(w_arb_idx)*DW +: DW];
                r_abort <= 1'b0;
            end
            if (w_capture) begin
                r_rx <= m_rx_data;
            end
            if (w_timeout) begin
                r_abort <= 1'b1;
            end
            if (w_finish) begin
                r_gnt  <= '0;
                r_done <= r_gnt;
                r_err  <= r_abort;
                r_ptr  <= (r_gidx == c_LAST_IDX) ? '0 : r_gidx + 1'b1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign ss_n      = ~r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rx_data   = r_rx;
    assign m_tx_data = r_tx;
    assign m_start   = (r_state == ST_START);

endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_req_arbiter
// Brief    : Directed vector bench for spi_req_arbiter with a simple SPI master model.
// Revision : 1.0
// ============================================================================
module tb_spi_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        m_busy = 1'b0;
    logic [7:0]  m_rx_data = '0;
    logic        mdl_done = 1'b0;
    logic        force_done = 1'b0;
    logic        m_done;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  rx_data;
    logic [3:0]  ss_n;
    logic        m_start;
    logic [7:0]  m_tx_data;

    int total = 0;
    int bad = 0;
    bit mdl_on = 1'b1;
    int mdl_cnt = 0;
    bit ss_bad = 1'b0;
    int start_cnt = 0;

    assign m_done = mdl_done | force_done;

    spi_req_arbiter #(
        .NREQ     (4),
        .DW       (8),
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .TIMEOUT  (255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rx_data   (rx_data),
        .ss_n      (ss_n),
        .m_start   (m_start),
        .m_tx_data (m_tx_data),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_rx_data (m_rx_data)
    );

    always #5 clk = ~clk;

    // Master model: completion pulse 8 clocks after the start pulse
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (!rst) begin
            mdl_cnt = 0;
        end else if (m_start && mdl_on) begin
            mdl_cnt = 8;
        end else if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0) mdl_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst && ($countones(~ss_n) > 1)) ss_bad = 1'b1;
        if (m_start) start_cnt = start_cnt + 1;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input logic [3:0] rq, input logic [31:0] d, input logic [7:0] rx,
                           input logic [3:0] eg, input logic [7:0] etx, input bit drop,
                           input logic exp_err, input logic [7:0] exp_rx, input int exp_lat,
                           input int inj);
        int n;
        req_data  = d;
        m_rx_data = rx;
        req       = rq;
        n = 0;
        do begin tick(); n++; end while (gnt == 4'h0 && n < 20);
        chk("grant_latency", n, 1);
        chk("grant", {28'h0, gnt}, {28'h0, eg});
        chk("ss_n_low", {28'h0, ss_n}, {28'h0, ~eg});
        chk("tx_latch", {24'h0, m_tx_data}, {24'h0, etx});
        req_data = ~d;
        if (drop) req = 4'h0;
        n = 0;
        while (!m_start && n < 20) begin tick(); n++; end
        chk("start_delay", n, 2);
        tick();
        chk("start_width", {31'h0, m_start}, 32'h0);
        chk("tx_stable", {24'h0, m_tx_data}, {24'h0, etx});
        n = 1;
        while (done == 4'h0 && n < 400) begin
            force_done = (n == inj);
            tick();
            n++;
        end
        force_done = 1'b0;
        chk("done_latency", n, exp_lat);
        chk("done_vec", {28'h0, done}, {28'h0, eg});
        chk("err", {31'h0, err}, {31'h0, exp_err});
        chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx});
        chk("gnt_released", {28'h0, gnt}, 32'h0);
        chk("ss_n_released", {28'h0, ss_n}, 32'hF);
        req = 4'h0;
        tick();
        chk("done_width", {28'h0, done}, 32'h0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  rx;
        logic [3:0]  gnt;
        logic [7:0]  tx;
        bit          drop;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   n;
        int   s0;
        int   order [5];
        logic [31:0] tmp;

        vecs[0] = '{req: 4'b0100, data: 32'h00A5_0000, rx: 8'h3C, gnt: 4'b0100, tx: 8'hA5, drop: 1'b0};
        vecs[1] = '{req: 4'b0011, data: 32'h0000_2211, rx: 8'h81, gnt: 4'b0001, tx: 8'h11, drop: 1'b1};
        vecs[2] = '{req: 4'b0011, data: 32'h0000_2211, rx: 8'h42, gnt: 4'b0010, tx: 8'h22, drop: 1'b0};
        vecs[3] = '{req: 4'b1001, data: 32'h7700_0066, rx: 8'hE7, gnt: 4'b1000, tx: 8'h77, drop: 1'b0};
        vecs[4] = '{req: 4'b1001, data: 32'h7700_0066, rx: 8'h18, gnt: 4'b0001, tx: 8'h66, drop: 1'b0};
        vecs[5] = '{req: 4'b0100, data: 32'h00C3_0000, rx: 8'h5A, gnt: 4'b0100, tx: 8'hC3, drop: 1'b0};
        order = '{0, 1, 2, 3, 0};

        // Reset and idle behaviour
        tick();
        tick();
        chk("rst_ss_n", {28'h0, ss_n}, 32'hF);
        chk("rst_gnt", {28'h0, gnt}, 32'h0);
        chk("rst_done", {28'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rx", {24'h0, rx_data}, 32'h0);
        chk("rst_tx", {24'h0, m_tx_data}, 32'h0);
        chk("rst_start", {31'h0, m_start}, 32'h0);
        rst = 1'b1;
        s0 = start_cnt;
        repeat (5) tick();
        chk("idle_no_start", start_cnt - s0, 0);
        chk("idle_ss_n", {28'h0, ss_n}, 32'hF);

        // Table-driven single transactions, exercising rotation and wrap
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].req, vecs[i].data, vecs[i].rx, vecs[i].gnt, vecs[i].tx,
                    vecs[i].drop, 1'b0, vecs[i].rx, 11, 0);
        end

        // Busy master blocks grant; stray m_done during SETUP ignored
        m_busy    = 1'b1;
        req       = 4'b0010;
        req_data  = 32'h0000_5500;
        m_rx_data = 8'hEE;
        s0 = 0;
        repeat (4) begin
            tick();
            if (gnt != 4'h0) s0 = 1;
        end
        chk("busy_no_grant", s0, 0);
        m_busy = 1'b0;
        tick();
        chk("busy_grant", {28'h0, gnt}, 32'h2);
        chk("busy_tx", {24'h0, m_tx_data}, 32'h55);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        m_rx_data  = 8'h99;
        n = 0;
        while (!m_start && n < 20) begin tick(); n++; end
        chk("stray_start_delay", n, 1);
        n = 0;
        while (done == 4'h0 && n < 400) begin tick(); n++; end
        chk("stray_done_latency", n, 11);
        chk("stray_done_vec", {28'h0, done}, 32'h2);
        chk("stray_rx", {24'h0, rx_data}, 32'h99);
        req = 4'h0;
        tick();

        // Timeout abort, then m_done coinciding with timeout
        mdl_on = 1'b0;
        run_txn(4'b0001, 32'h0000_00AB, 8'h12, 4'b0001, 8'hAB, 1'b0, 1'b1, 8'h99, 258, 0);
        run_txn(4'b0100, 32'h00CD_0000, 8'h4E, 4'b0100, 8'hCD, 1'b0, 1'b0, 8'h4E, 258, 255);
        mdl_on = 1'b1;

        // Asynchronous reset during WAIT
        req      = 4'b1000;
        req_data = 32'hF000_0000;
        n = 0;
        do begin tick(); n++; end while (gnt == 4'h0 && n < 20);
        chk("mid_rst_grant", {28'h0, gnt}, 32'h8);
        n = 0;
        while (!m_start && n < 20) begin tick(); n++; end
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_ss_n", {28'h0, ss_n}, 32'hF);
        chk("async_gnt", {28'h0, gnt}, 32'h0);
        req = 4'h0;
        s0 = 0;
        repeat (20) begin
            tick();
            if (done != 4'h0) s0 = 1;
        end
        chk("rst_no_done", s0, 0);
        rst = 1'b1;
        run_txn(4'b1000, 32'h3300_0000, 8'hB2, 4'b1000, 8'h33, 1'b0, 1'b0, 8'hB2, 11, 0);

        // All requesting: strict rotation with an idle gap between transactions
        req       = 4'hF;
        req_data  = 32'h4433_2211;
        m_rx_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin tick(); n++; end while (gnt == 4'h0 && n < 20);
            tmp = req_data >> (8 * order[i]);
            chk("rr_latency", n, 1);
            chk("rr_gnt", {28'h0, gnt}, 32'h1 << order[i]);
            chk("rr_tx", {24'h0, m_tx_data}, {24'h0, tmp[7:0]});
            n = 0;
            while (done == 4'h0 && n < 400) begin tick(); n++; end
            chk("rr_done", {28'h0, done}, 32'h1 << order[i]);
            chk("rr_gap_ss_n", {28'h0, ss_n}, 32'hF);
        end
        req = 4'h0;
        tick();
        chk("ss_onehot", {31'h0, ss_bad}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
